// File: rtl/uart_alu_frame_ctrl_if.sv
// RX/TX FIFO, ALU and status bundle of the UART<->ALU frame controller.
// master = controller side, slave = FIFO/ALU environment side.
interface uart_alu_frame_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_BYTES   = 2,
   parameter int OPCODE_SZ  = 6,
   parameter int RES_BYTES  = 2
);
   logic                            i_rx_empty;
   logic [DATA_WIDTH-1:0]           i_r_data;
   logic                            i_tx_full;
   logic [RES_BYTES*DATA_WIDTH-1:0] i_result;
   logic                            o_rd_uart;
   logic                            o_wr_uart;
   logic [DATA_WIDTH-1:0]           o_w_data;
   logic [OP_BYTES*DATA_WIDTH-1:0]  o_op_a;
   logic [OP_BYTES*DATA_WIDTH-1:0]  o_op_b;
   logic [OPCODE_SZ-1:0]            o_op_code;
   logic                            o_busy;
   logic                            o_done;
   logic                            o_frame_err;

   modport master (
      input  i_rx_empty, i_r_data, i_tx_full, i_result,
      output o_rd_uart, o_wr_uart, o_w_data, o_op_a, o_op_b, o_op_code,
             o_busy, o_done, o_frame_err
   );

   modport slave (
      output i_rx_empty, i_r_data, i_tx_full, i_result,
      input  o_rd_uart, o_wr_uart, o_w_data, o_op_a, o_op_b, o_op_code,
             o_busy, o_done, o_frame_err
   );
endinterface

// File: rtl/uart_alu_frame_ctrl.sv
// Collects A, B, opcode bytes from the RX FIFO, applies them atomically to the ALU and
// returns the result LSB first; 2*OP_BYTES+1 pops, ALU_LAT wait, RES_BYTES pushes (TX full stalls).
module uart_alu_frame_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int OP_BYTES    = 2,
   parameter int OPCODE_SZ   = 6,
   parameter int RES_BYTES   = 2,
   parameter int ALU_LAT     = 1,
   parameter int TIMEOUT_CYC = 100000
) (
   input logic                   i_clk,
   input logic                   i_reset,
   uart_alu_frame_ctrl_if.master bus
);
   localparam int OPW     = OP_BYTES * DATA_WIDTH;
   localparam int RESW    = RES_BYTES * DATA_WIDTH;
   localparam int CNT_M0  = (OP_BYTES > RES_BYTES) ? OP_BYTES : RES_BYTES;
   localparam int CNT_MAX = (CNT_M0 > ALU_LAT) ? CNT_M0 : ALU_LAT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int TMO_W   = $clog2(TIMEOUT_CYC);

   localparam logic [CNT_W-1:0] OP_LAST  = CNT_W'(OP_BYTES - 1);
   localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_BYTES - 1);
   localparam logic [CNT_W-1:0] ALU_LAST = CNT_W'(ALU_LAT - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      RX_A     = 3'd0,
      RX_B     = 3'd1,
      RX_OP    = 3'd2,
      ALU_WAIT = 3'd3,
      TX       = 3'd4
   } state_t;

   state_t                 state_q,     state_d;
   logic [CNT_W-1:0]       cnt_q,       cnt_d;
   logic [TMO_W-1:0]       tmo_q,       tmo_d;
   logic [OPW-1:0]         shadow_a_q,  shadow_a_d;
   logic [OPW-1:0]         shadow_b_q,  shadow_b_d;
   logic [OPW-1:0]         op_a_q,      op_a_d;
   logic [OPW-1:0]         op_b_q,      op_b_d;
   logic [OPCODE_SZ-1:0]   op_code_q,   op_code_d;
   logic [RESW-1:0]        shift_q,     shift_d;
   logic                   done_q,      done_d;
   logic                   frame_err_q, frame_err_d;

   logic rx_phase;
   logic in_frame;
   logic pop;
   logic push;

   assign rx_phase = (state_q == RX_A) || (state_q == RX_B) || (state_q == RX_OP);
   assign in_frame = rx_phase && !((state_q == RX_A) && (cnt_q == '0));
   // Reset gating keeps the pop strobe low while reset is held with a non-empty FIFO.
   assign pop      = rx_phase && !bus.i_rx_empty && !i_reset;
   assign push     = (state_q == TX) && !bus.i_tx_full;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      shadow_a_d  = shadow_a_q;
      shadow_b_d  = shadow_b_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_code_d   = op_code_q;
      shift_d     = shift_q;
      done_d      = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         RX_A: begin
            if (pop) begin
               for (int i = 0; i < OP_BYTES; i++) begin
                  if (cnt_q == CNT_W'(i)) shadow_a_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.i_r_data;
               end
               if (cnt_q == OP_LAST) begin
                  state_d = RX_B;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RX_B: begin
            if (pop) begin
               for (int i = 0; i < OP_BYTES; i++) begin
                  if (cnt_q == CNT_W'(i)) shadow_b_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.i_r_data;
               end
               if (cnt_q == OP_LAST) begin
                  state_d = RX_OP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RX_OP: begin
            if (pop) begin
               op_a_d    = shadow_a_q;
               op_b_d    = shadow_b_q;
               op_code_d = bus.i_r_data[OPCODE_SZ-1:0];
               state_d   = ALU_WAIT;
               cnt_d     = '0;
            end
         end
         ALU_WAIT: begin
            if (cnt_q == ALU_LAST) begin
               shift_d = bus.i_result;
               state_d = TX;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         TX: begin
            if (push) begin
               shift_d = shift_q >> DATA_WIDTH;
               if (cnt_q == RES_LAST) begin
                  state_d = RX_A;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = RX_A;
            cnt_d   = '0;
         end
      endcase

      // Idle timer only runs mid-frame; a pop on the expiry cycle wins.
      if (pop || !in_frame) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
         state_d     = RX_A;
         cnt_d       = '0;
         tmo_d       = '0;
         shadow_a_d  = '0;
         shadow_b_d  = '0;
         frame_err_d = 1'b1;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= RX_A;
         cnt_q       <= '0;
         tmo_q       <= '0;
         shadow_a_q  <= '0;
         shadow_b_q  <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_code_q   <= '0;
         shift_q     <= '0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         shadow_a_q  <= shadow_a_d;
         shadow_b_q  <= shadow_b_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_code_q   <= op_code_d;
         shift_q     <= shift_d;
         done_q      <= done_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign bus.o_rd_uart   = pop;
   assign bus.o_wr_uart   = push;
   assign bus.o_w_data    = shift_q[DATA_WIDTH-1:0];
   assign bus.o_op_a      = op_a_q;
   assign bus.o_op_b      = op_b_q;
   assign bus.o_op_code   = op_code_q;
   assign bus.o_busy      = !((state_q == RX_A) && (cnt_q == '0));
   assign bus.o_done      = done_q;
   assign bus.o_frame_err = frame_err_q;
endmodule
